mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Parametrised successor to the fixed-rotation switch arbiter.
- Arbitrates N port controllers onto one shared packet-buffer memory, with independent write and read channels.
- Each channel uses work-conserving round-robin with req/gnt handshakes and a bounded burst lock.
- Read data is routed back to the issuing port through an in-flight tag pipeline sized to the memory read latency.

Parameters:
- N, 4: number of ports; any value ≥2, not restricted to a power of two.
- RD_LAT, 1: cycles from the mem_re_o cycle to mem_rvalid_i; ≥1.
- MAX_BURST, 4: maximum consecutive grants to one port per channel before forced rotation; ≥1.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- wr_req_i  in  N  per-port write request
- wr_addr_i  in  N×ADDR_W  per-port write block address
- wr_data_i  in  N×BLOCK_BITS  per-port write data
- wr_gnt_o  out  N  one-hot write grant
- mem_we_o  out  1  memory write enable
- mem_waddr_o  out  ADDR_W  memory write address
- mem_wdata_o  out  BLOCK_BITS  memory write data
- rd_req_i  in  N  per-port read request
- rd_addr_i  in  N×ADDR_W  per-port read address
- rd_gnt_o  out  N  one-hot read grant
- mem_re_o  out  1  memory read enable
- mem_raddr_o  out  ADDR_W  memory read address
- mem_rvalid_i  in  1  memory read data valid
- mem_rdata_i  in  BLOCK_BITS  memory read data
- rd_valid_o  out  N  one-hot read-return valid
- rd_data_o  out  BLOCK_BITS  read-return data, shared bus
- err_o  out  1  sticky: rvalid arrived with no matching tag
- (ARB_STATS_EN only) stat_sel_i  in  $clog2(N)  counter select
- (ARB_STATS_EN only) stat_cnt_o  out  16  selected counter value

Behaviour:
- Reset (async, rst_n low):
  - both round-robin pointers = 0
  - burst counters = 0
  - tag pipeline cleared
  - err_o = 0; all counters = 0
  - all outputs 0 whenever no request is present.
- Grant is combinational, same cycle as the request:
  - Grant goes to the first requester at or after the pointer, wrapping modulo N.
  - gnt is 0 when no requests are present (work-conserving; idle ports never consume slots).
- A transfer occurs on any cycle where req && gnt for a port.
  - Requesters hold req, addr and data stable until granted.
  - Dropping req before grant is legal; the request is withdrawn.
- Memory outputs:
  - mem_we_o = |wr_gnt_o, with mem_waddr_o/mem_wdata_o muxed from the granted port; zero when idle.
  - The read side is identical.
- Pointer and burst update (registered, per channel), granted port g:
  - If g is the same as last cycle's grant and burst_cnt+1 < MAX_BURST: pointer stays at g; burst_cnt++.
  - Otherwise: pointer = (g+1) mod N; burst_cnt = 0 when rotating.
  - burst_cnt resets to 0 on any idle cycle.
  - MAX_BURST=1 gives pure round robin.
- Read tag pipeline:
  - RD_LAT-deep shift register of {valid, port index}, loaded on every cycle; valid = |rd_gnt_o.
  - Output stage tag is compared on mem_rvalid_i:
    - Tag valid: rd_valid_o[tag.port]=1 and rd_data_o=mem_rdata_i, combinational in that cycle.
    - Tag invalid: all rd_valid_o=0 and err_o set, sticky until reset.
  - A valid tag arriving without mem_rvalid_i is dropped silently.
- Write and read channels are fully independent; simultaneous write and read grants are legal every cycle.
- Reset asserted mid-burst or with reads in flight:
  - All state clears immediately.
  - Any data returning after reset deasserts is flagged via err_o.

Optional Feature:
- Macro: ARB_STATS_EN.
- Defined:
  - Per-port 16-bit saturating counters of write transfers, held at 0xFFFF once reached.
  - stat_cnt_o = counter[stat_sel_i], registered with 1-cycle latency.
  - stat_sel_i ≥ N returns 0.
- Undefined: stat ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- mem_pkg: ADDR_W and BLOCK_BITS (existing). Add arb_tag_t as a struct of {valid, port index sized for the maximum N=16}.
- Sub-module rr_arbiter_core:
  - parameters N and MAX_BURST
  - contains req → one-hot gnt, pointer and burst counter
  - instantiated twice, once for write and once for read.

Test Plan:
- Round robin: N=4, MAX_BURST=1, wr_req_i=4'b1111 held → grant sequence 0,1,2,3,0…; one mem_we_o per cycle.
- Work conserving: only port 2 requests, MAX_BURST=4 → grant 2 on every cycle.
  - Then ports 2 and 3 request, with port 2 already mid-burst → port 2 holds until its 4-grant count completes, then port 3 is granted.
- Read return routing: RD_LAT=3; port 1 reads 0x10, port 3 reads 0x20 on consecutive cycles; memory returns D1, D3 at +3 → rd_valid_o=0010 with D1, then 1000 with D3.
- Orphan rvalid: assert mem_rvalid_i with no reads outstanding → rd_valid_o=0 and err_o=1, held until rst_n low.
- Reset mid-operation: pull rst_n low with 2 reads in flight → all outputs 0 and pointer 0. After release, requests 4'b1000 → grant port 3 first.
- ARB_STATS_EN: 70000 port-0 writes → stat_sel_i=0 gives 0xFFFF; stat_sel_i=5 gives 0.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared packet-buffer memory geometry and the read-return tag carried by the arbiter.
package mem_pkg;

    localparam int ADDR_W     = 8;
    localparam int BLOCK_BITS = 32;
    localparam int MAX_PORTS  = 16;
    localparam int PORT_W     = $clog2(MAX_PORTS);

    typedef struct packed {
        logic              valid;
        logic [PORT_W-1:0] port;
    } arb_tag_t;

endpackage

// File: rtl/rr_arbiter_core.sv
// Work-conserving round-robin arbiter with a bounded burst lock on the last winner.
module rr_arbiter_core #(
    parameter int N         = 4,
    parameter int MAX_BURST = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_idx
);

    localparam int PW = $clog2(N);
    localparam int BW = $clog2(MAX_BURST + 1);

    logic [PW-1:0] ptr;
    logic [PW-1:0] ptr_nxt;
    logic [BW-1:0] burst_cnt;
    logic [BW-1:0] burst_nxt;
    logic [BW-1:0] run_len;
    logic          hold;
    logic          hold_nxt;
    logic          busy;
    int unsigned   cand;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        busy    = 1'b0;
        cand    = 0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = 32'(ptr) + k;
            if (cand >= N) cand = cand - N;
            if (!busy && req[PW'(cand)]) begin
                busy              = 1'b1;
                gnt[PW'(cand)]    = 1'b1;
                gnt_idx           = PW'(cand);
            end
        end
    end

    // hold marks a live burst parked on ptr; a new winner always starts its count at one grant
    always_comb begin
        run_len   = (hold && req[ptr]) ? burst_cnt + BW'(1) : '0;
        ptr_nxt   = ptr;
        burst_nxt = '0;
        hold_nxt  = 1'b0;
        if (busy) begin
            if (int'(run_len) + 1 < MAX_BURST) begin
                ptr_nxt   = gnt_idx;
                burst_nxt = run_len;
                hold_nxt  = 1'b1;
            end else begin
                ptr_nxt = (gnt_idx == PW'(N - 1)) ? '0 : gnt_idx + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr       <= '0;
            burst_cnt <= '0;
            hold      <= 1'b0;
        end else begin
            ptr       <= ptr_nxt;
            burst_cnt <= burst_nxt;
            hold      <= hold_nxt;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// N-port write/read arbiter for the shared packet buffer with tagged read-return routing.
// Define ARB_STATS_EN to add per-port saturating write-transfer counters.
module mem_port_arbiter
    import mem_pkg::*;
#(
    parameter int N         = 4,
    parameter int RD_LAT    = 1,
    parameter int MAX_BURST = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N-1:0]            wr_req_i,
    input  logic [N*ADDR_W-1:0]     wr_addr_i,
    input  logic [N*BLOCK_BITS-1:0] wr_data_i,
    output logic [N-1:0]            wr_gnt_o,
    output logic                    mem_we_o,
    output logic [ADDR_W-1:0]       mem_waddr_o,
    output logic [BLOCK_BITS-1:0]   mem_wdata_o,
    input  logic [N-1:0]            rd_req_i,
    input  logic [N*ADDR_W-1:0]     rd_addr_i,
    output logic [N-1:0]            rd_gnt_o,
    output logic                    mem_re_o,
    output logic [ADDR_W-1:0]       mem_raddr_o,
    input  logic                    mem_rvalid_i,
    input  logic [BLOCK_BITS-1:0]   mem_rdata_i,
    output logic [N-1:0]            rd_valid_o,
    output logic [BLOCK_BITS-1:0]   rd_data_o,
    output logic                    err_o
`ifdef ARB_STATS_EN
    ,
    input  logic [$clog2(N)-1:0]    stat_sel_i,
    output logic [15:0]             stat_cnt_o
`endif
);

    localparam int PW = $clog2(N);

    logic [PW-1:0] wr_idx;
    logic [PW-1:0] rd_idx;
    arb_tag_t      tag_pipe [RD_LAT];
    arb_tag_t      tag_in;
    arb_tag_t      tag_out;

    rr_arbiter_core #(.N(N), .MAX_BURST(MAX_BURST)) u_wr_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (wr_req_i),
        .gnt     (wr_gnt_o),
        .gnt_idx (wr_idx)
    );

    rr_arbiter_core #(.N(N), .MAX_BURST(MAX_BURST)) u_rd_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (rd_req_i),
        .gnt     (rd_gnt_o),
        .gnt_idx (rd_idx)
    );

    assign mem_we_o    = |wr_gnt_o;
    assign mem_waddr_o = mem_we_o ? wr_addr_i[wr_idx*ADDR_W +: ADDR_W] : '0;
    assign mem_wdata_o = mem_we_o ? wr_data_i[wr_idx*BLOCK_BITS +: BLOCK_BITS] : '0;

    assign mem_re_o    = |rd_gnt_o;
    assign mem_raddr_o = mem_re_o ? rd_addr_i[rd_idx*ADDR_W +: ADDR_W] : '0;

    always_comb begin
        tag_in.valid = mem_re_o;
        tag_in.port  = PORT_W'(rd_idx);
    end

    assign tag_out = tag_pipe[RD_LAT-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < RD_LAT; i++) tag_pipe[i] <= '0;
        end else begin
            tag_pipe[0] <= tag_in;
            for (int unsigned i = 1; i < RD_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
        end
    end

    always_comb begin
        rd_valid_o = '0;
        rd_data_o  = '0;
        if (mem_rvalid_i && tag_out.valid) begin
            for (int unsigned i = 0; i < N; i++) rd_valid_o[i] = (tag_out.port == PORT_W'(i));
            rd_data_o = mem_rdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_o <= 1'b0;
        end else if (mem_rvalid_i && !tag_out.valid) begin
            err_o <= 1'b1;
        end
    end

`ifdef ARB_STATS_EN
    logic [15:0] wr_cnt [N];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < N; i++) wr_cnt[i] <= '0;
            stat_cnt_o <= '0;
        end else begin
            for (int unsigned i = 0; i < N; i++) begin
                if (wr_gnt_o[i] && wr_cnt[i] != '1) wr_cnt[i] <= wr_cnt[i] + 16'd1;
            end
            stat_cnt_o <= (int'(stat_sel_i) < N) ? wr_cnt[stat_sel_i] : '0;
        end
    end
`endif

endmodule
